// File: rtl/led_fb_pkg.sv
// Shared types and helpers for the LED feedback driver: lane state encoding,
// LED drive levels and the lane timer width calculation.
package led_fb_pkg;

    typedef enum logic [1:0] {
        LS_IDLE = 2'd0,
        LS_HOLD = 2'd1,
        LS_FADE = 2'd2
    } lane_state_t;

    localparam logic LED_ON  = 1'b1;
    localparam logic LED_OFF = 1'b0;

    // Wide enough for the larger of the two reload values; never narrower than one bit.
    function automatic int timer_width(input int hold_cycles, input int step_cycles);
        int longest;
        int width;
        longest = (hold_cycles > step_cycles) ? hold_cycles : step_cycles;
        width   = $clog2(longest);
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/led_fb_lane.sv
// One LED lane: hold-then-fade sequencer with a shared-PWM comparator.
// The lane timer is a down-counter; phase changes happen on terminal count.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  LS_IDLE | lane dark, waiting for a hit
//  LS_HOLD | lane fully lit, timer counting down the hold time
//  LS_FADE | lane PWM-driven at duty_q, duty drops one step per timer expiry
module led_fb_lane
    import led_fb_pkg::*;
#(
    parameter int PWM_BITS    = 4,
    parameter int HOLD_CYCLES = 2_500_000,
    parameter int STEP_CYCLES = 390_625
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                hit,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led,
    output logic                active
);

    localparam int                TW         = timer_width(HOLD_CYCLES, STEP_CYCLES);
    localparam logic [TW-1:0]     HOLD_LOAD  = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0]     STEP_LOAD  = TW'(STEP_CYCLES - 1);
    localparam logic [TW-1:0]     TIMER_ONE  = TW'(1);
    localparam logic [PWM_BITS-1:0] DUTY_FULL = '1;
    localparam logic [PWM_BITS-1:0] DUTY_MIN  = PWM_BITS'(1);

    lane_state_t          state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [PWM_BITS-1:0]  duty_q, duty_d;
    logic [PWM_BITS-1:0]  pwm_nxt;
    logic                 led_q, led_d;
    logic                 active_q, active_d;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        duty_d  = duty_q;

        if (!enable) begin
            state_d = LS_IDLE;
            timer_d = '0;
            duty_d  = '0;
        end else if (hit) begin
            state_d = LS_HOLD;
            timer_d = HOLD_LOAD;
            duty_d  = '0;
        end else begin
            case (state_q)
                LS_HOLD: begin
                    if (timer_q == '0) begin
                        state_d = LS_FADE;
                        duty_d  = DUTY_FULL;
                        timer_d = STEP_LOAD;
                    end else begin
                        timer_d = timer_q - TIMER_ONE;
                    end
                end
                LS_FADE: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - TIMER_ONE;
                    end else if (duty_q <= DUTY_MIN) begin
                        state_d = LS_IDLE;
                        duty_d  = '0;
                    end else begin
                        duty_d  = duty_q - DUTY_MIN;
                        timer_d = STEP_LOAD;
                    end
                end
                default: begin
                    state_d = LS_IDLE;
                end
            endcase
        end
    end

    // The LED is registered, so compare against the PWM value the counter will hold next cycle.
    always_comb begin
        pwm_nxt  = pwm_cnt + PWM_BITS'(1);
        led_d    = LED_OFF;
        active_d = (state_d != LS_IDLE);
        case (state_d)
            LS_HOLD: led_d = LED_ON;
            LS_FADE: led_d = (pwm_nxt < duty_d) ? LED_ON : LED_OFF;
            default: led_d = LED_OFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LS_IDLE;
            timer_q  <= '0;
            duty_q   <= '0;
            led_q    <= LED_OFF;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            duty_q   <= duty_d;
            led_q    <= led_d;
            active_q <= active_d;
        end
    end

    assign led    = led_q;
    assign active = active_q;

endmodule

// File: rtl/led_feedback_driver.sv
// Per-fret LED feedback: each hit lights its lane for a hold time, then PWM-fades it out.
// All lanes share one free-running PWM counter so their fades stay phase-aligned.
module led_feedback_driver
    import led_fb_pkg::*;
#(
    parameter int N_LANES     = 5,
    parameter int PWM_BITS    = 4,
    parameter int HOLD_CYCLES = 2_500_000,
    parameter int STEP_CYCLES = 390_625
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [N_LANES-1:0] hit,
    output logic [N_LANES-1:0] led,
    output logic [N_LANES-1:0] active
);

    if (HOLD_CYCLES < 1 || STEP_CYCLES < 1 || PWM_BITS < 1 || N_LANES < 1) begin : g_param_check
        $error("led_feedback_driver: HOLD_CYCLES, STEP_CYCLES, PWM_BITS and N_LANES must all be >= 1");
    end

    logic [PWM_BITS-1:0] pwm_cnt_q;

    // Runs regardless of enable so lanes re-enabled later see a consistent phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
        end
    end

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        led_fb_lane #(
            .PWM_BITS    (PWM_BITS),
            .HOLD_CYCLES (HOLD_CYCLES),
            .STEP_CYCLES (STEP_CYCLES)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .enable  (enable),
            .hit     (hit[g]),
            .pwm_cnt (pwm_cnt_q),
            .led     (led[g]),
            .active  (active[g])
        );
    end

endmodule
